// File: rtl/err_pkg.sv
// rtl/err_pkg.sv - shared types and constants for the error sequencer
package err_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLR   = 2'd1,
      ACCUM = 2'd2,
      DONE  = 2'd3
   } err_state_t;

   // Number of weighted IR terms summed per sample set
   localparam int NUM_TERMS = 8;

   // Width of the datapath operand select
   localparam int SEL_W = 3;

   // Operand select encoding: even = right sensors (added), odd = left (subtracted)
   localparam logic [SEL_W-1:0] SEL_R0 = 3'd0;
   localparam logic [SEL_W-1:0] SEL_L0 = 3'd1;
   localparam logic [SEL_W-1:0] SEL_R1 = 3'd2;
   localparam logic [SEL_W-1:0] SEL_L1 = 3'd3;
   localparam logic [SEL_W-1:0] SEL_R2 = 3'd4;
   localparam logic [SEL_W-1:0] SEL_L2 = 3'd5;
   localparam logic [SEL_W-1:0] SEL_R3 = 3'd6;
   localparam logic [SEL_W-1:0] SEL_L3 = 3'd7;

   // Counter value of the last term in ACCUM
   localparam logic [SEL_W-1:0] CNT_LAST = SEL_W'(NUM_TERMS - 1);

endpackage

// File: rtl/err_compute_sm.sv
// rtl/err_compute_sm.sv - accumulate sequencer for the line-follower error datapath
module err_compute_sm
   import err_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             IR_vld,
   input  logic             clr_ovr,
   output logic             clr_accum,
   output logic             en_accum,
   output logic             sub,
   output logic [SEL_W-1:0] sel,
   output logic             busy,
   output logic             err_vld,
   output logic             ovr
);

   err_state_t       state_q;
   err_state_t       state_d;
   logic [SEL_W-1:0] cnt_q;
   logic [SEL_W-1:0] cnt_d;
   logic             ovr_q;
   logic             ovr_set;

   // State and term counter registers; reset aborts any sequence in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= SEL_R0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state and counter: one clear cycle, eight accumulate cycles, one done cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = SEL_R0;
            if (IR_vld) begin
               state_d = CLR;
            end
         end
         CLR: begin
            cnt_d   = SEL_R0;
            state_d = ACCUM;
         end
         ACCUM: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = SEL_R0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + SEL_W'(1);
            end
         end
         DONE: begin
            // A new sample set arriving here starts straight away; not an overrun
            cnt_d   = SEL_R0;
            state_d = IR_vld ? CLR : IDLE;
         end
         default: begin
            cnt_d   = SEL_R0;
            state_d = IDLE;
         end
      endcase
   end

   // Moore output decode from state and term counter
   always_comb begin
      clr_accum = 1'b0;
      en_accum  = 1'b0;
      sub       = 1'b0;
      sel       = SEL_R0;
      busy      = 1'b0;
      err_vld   = 1'b0;
      case (state_q)
         CLR: begin
            clr_accum = 1'b1;
            busy      = 1'b1;
         end
         ACCUM: begin
            en_accum = 1'b1;
            sel      = cnt_q;
            sub      = cnt_q[0];
            busy     = 1'b1;
         end
         DONE: begin
            err_vld = 1'b1;
            busy    = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // A sample set arriving mid-sequence is dropped and flagged
   assign ovr_set = IR_vld && ((state_q == CLR) || (state_q == ACCUM));

   // Sticky overrun flag; a new overrun beats a simultaneous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovr_q <= 1'b0;
      end else if (ovr_set) begin
         ovr_q <= 1'b1;
      end else if (clr_ovr) begin
         ovr_q <= 1'b0;
      end
   end

   assign ovr = ovr_q;

endmodule

// File: doc/err_compute_sm.md
Name: err_compute_sm

Overview:
- Sequencer for the line-follower error datapath (err_compute_DP). It drives err_compute_DP's accumulator controls (clr_accum, en_accum, sub, sel).
- On each new IR sample set (IR_vld) it clears the accumulator, then steps through the 8 weighted IR terms. Right readings are added and left readings subtracted.
- When the accumulated error is final, it issues a one-cycle err_vld strobe to the PID block.
- It also reports busy status and flags IR samples lost to overrun.

Parameters:
None. The term count is fixed at 8 (constant NUM_TERMS in the package).

Ports:
clk        input   1  50MHz system clock
rst_n      input   1  asynchronous active-low reset
IR_vld     input   1  pulse: new IR_R0..3 / IR_L0..3 readings are stable and held until err_vld
clr_ovr    input   1  synchronous clear of the ovr sticky flag
clr_accum  output  1  to datapath: zero the error accumulator
en_accum   output  1  to datapath: accumulate the selected term this cycle
sub        output  1  to datapath: subtract (two's complement) the selected term
sel        output  3  to datapath: operand select, 0..7 = R0,L0,R1,L1,R2,L2,R3,L3
busy       output  1  high whenever state != IDLE
err_vld    output  1  one-cycle strobe: datapath error output is final
ovr        output  1  sticky: IR_vld arrived while a sequence was in CLR or ACCUM

Behaviour:
- States: IDLE, CLR, ACCUM, DONE.
- Outputs are Moore outputs decoded from state and term counter cnt[2:0].
- Reset (async, rst_n low):
  - state = IDLE, cnt = 0, ovr = 0.
  - All outputs 0; sel = 0.
  - Reset mid-sequence aborts immediately. No err_vld is issued for the aborted sequence.
- IDLE:
  - All controls 0.
  - IR_vld = 1 -> CLR.
- CLR (1 cycle):
  - clr_accum = 1, en_accum = 0.
  - cnt <= 0.
  - Next state: ACCUM.
- ACCUM (exactly 8 cycles):
  - en_accum = 1, sel = cnt, sub = cnt[0], so odd selects (left sensors) are subtracted.
  - cnt increments each cycle.
  - When cnt == 7: next state DONE and cnt <= 0. The counter never wraps inside ACCUM.
- DONE (1 cycle):
  - err_vld = 1, en_accum = 0. The datapath error register holds the final value this cycle.
  - IR_vld = 1 in DONE -> CLR, giving a back-to-back sequence with no IDLE gap. This is not an overrun.
  - Otherwise -> IDLE.
- Latency:
  - IR_vld sampled high at edge 0 -> CLR in cycle 1, ACCUM in cycles 2..9, err_vld high in cycle 10.
  - Minimum IR_vld spacing without overrun: 10 clocks.
- Overrun:
  - IR_vld = 1 while in CLR or ACCUM sets ovr <= 1.
  - The request is dropped; the sequence in flight continues unaffected.
  - clr_ovr = 1 clears ovr. If clr_ovr and a new overrun occur in the same cycle, set wins (ovr = 1).
- Mutual exclusion:
  - clr_accum and en_accum are never high in the same cycle.
  - err_vld is never high while busy is low.
- Arithmetic: the block performs none.
  - Two's complement subtraction is done by the datapath: invert the operand plus carry-in from sub.
  - Term weighting (x1, x2, x4, x8) is fixed by sel inside the datapath.
- Unused state encodings recover to IDLE.

Decomposition:
- Shared package err_pkg:
  - typedef enum logic [1:0] err_state_t {IDLE, CLR, ACCUM, DONE}
  - localparam NUM_TERMS = 8
  - localparam SEL_W = 3
  - sel encoding constants SEL_R0..SEL_L3
- No sub-module. State register, counter and ovr flag live in one module.
- The integration wrapper (line-follower error top) instantiates err_compute_sm and err_compute_DP side by side.

Test Plan:
1. Reset: rst_n low, with IR_vld toggling -> all outputs 0, busy = 0. After release, nothing happens until IR_vld.
2. R0 = 0x010, all others 0, IR_vld pulse at edge 0 -> clr_accum high in cycle 1, sel = 0..7 in cycles 2..9, err_vld in cycle 10 only, error = 0x0010.
3. All eight IR = 0x100 -> error = 0x0000 at err_vld. L3 = 0xFFF, others 0 -> error = 0x8008 (-32760).
4. IR_vld re-pulsed in DONE (cycle 10) -> CLR in cycle 11, second err_vld in cycle 20, ovr stays 0.
5. IR_vld re-pulsed in cycle 5 -> ovr = 1, first err_vld still in cycle 10 with correct error, no second sequence. clr_ovr pulse -> ovr = 0. Simultaneous clr_ovr and overrun -> ovr = 1.
6. rst_n asserted in cycle 6 (ACCUM) -> outputs 0 at once, no err_vld. A new IR_vld after release gives a clean sequence with correct error.
